// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Holds the memory-handshake FSM state encoding and the default sizing
// constants used by the top module and its performance counters.
package pipeline_stall_controller_pkg;

    // Memory handshake sequencer states. RELEASE is the single cycle in
    // which a finished SRAM access lets the pipeline advance again.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } stall_state_e;

    // Default sizing for the performance counters and the SRAM watchdog.
    localparam int DEFAULT_CNT_W       = 32;
    localparam int DEFAULT_MEM_TIMEOUT = 64;
    localparam int DEFAULT_TO_W        = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall-controller performance counters.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears the count
//   clr   - synchronous clear, wins over inc
//   inc   - add one at the next edge unless already at all-ones
//   count - current count value (W bits)
module sat_counter
    import pipeline_stall_controller_pkg::*;
#(
    parameter int W = DEFAULT_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: a clear always beats an increment, and once the
    // counter reaches all-ones it holds there instead of wrapping to zero,
    // so a long run never reports a misleadingly small figure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges the hazard unit's stall request, the EXE taken-branch signal and
// the multi-cycle SRAM handshake into PC/stage-register freeze, bubble and
// flush controls, and keeps saturating performance counters plus a sticky
// memory-timeout flag.
// Ports:
//   clk, rst                 - clock (rising edge), async active-high reset
//   hazard_Detected          - RAW hazard stall request
//   Branch_Taken             - taken branch resolved in EXE
//   MEM_R_EN, MEM_W_EN       - MEM-stage load / store request
//   sram_ready               - SRAM access completes this cycle
//   cnt_clr                  - synchronous clear of counters and mem_timeout
//   freeze_PC, freeze_IF_ID  - hold PC / IF-ID register (hazard stall)
//   bubble_ID_EXE            - inject NOP into ID/EXE (hazard stall)
//   flush_IF_ID, flush_ID_EXE- squash younger instructions (taken branch)
//   freeze_all               - hold every stage register (SRAM wait)
//   mem_timeout              - sticky: an SRAM wait exceeded MEM_TIMEOUT
//   stall_cnt, flush_cnt, mem_wait_cnt - saturating event counters
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int TO_W        = DEFAULT_TO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_Detected,
    input  logic             Branch_Taken,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic             sram_ready,
    input  logic             cnt_clr,
    output logic             freeze_PC,
    output logic             freeze_IF_ID,
    output logic             bubble_ID_EXE,
    output logic             flush_IF_ID,
    output logic             flush_ID_EXE,
    output logic             freeze_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

    stall_state_e    state;
    stall_state_e    state_next;
    logic            mem_req;
    logic            mem_freeze;
    logic [TO_W-1:0] wait_cnt;

    assign mem_req = MEM_R_EN | MEM_W_EN;

    // State register for the SRAM handshake. Reset drops straight back to
    // IDLE even in the middle of a wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the freeze it implies. A zero-wait access (ready
    // in the same cycle as the request) never leaves IDLE. In RELEASE the
    // request line still shows the retiring instruction, so it is ignored.
    always_comb begin
        state_next = state;
        mem_freeze = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !sram_ready) begin
                    state_next = WAIT;
                    mem_freeze = 1'b1;
                end
            end
            WAIT: begin
                if (sram_ready) begin
                    state_next = RELEASE;
                end else begin
                    mem_freeze = 1'b1;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control priority: reset, then the memory freeze, then a taken branch,
    // then a hazard stall. While frozen the branch sits in EXE untouched and
    // is seen again once the freeze drops. A branch squashes the instruction
    // that raised the hazard, so the stall is pointless and is suppressed.
    always_comb begin
        freeze_PC     = 1'b0;
        freeze_IF_ID  = 1'b0;
        bubble_ID_EXE = 1'b0;
        flush_IF_ID   = 1'b0;
        flush_ID_EXE  = 1'b0;
        freeze_all    = 1'b0;
        if (rst) begin
            freeze_all = 1'b0;
        end else if (mem_freeze) begin
            freeze_all = 1'b1;
        end else if (Branch_Taken) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EXE = 1'b1;
        end else if (hazard_Detected) begin
            freeze_PC     = 1'b1;
            freeze_IF_ID  = 1'b1;
            bubble_ID_EXE = 1'b1;
        end
    end

    // Wait-cycle counter: restarts from zero on every entry into WAIT and
    // counts each WAIT cycle, parking at all-ones on very long waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state == IDLE) && (state_next == WAIT)) begin
            wait_cnt <= '0;
        end else if ((state == WAIT) && (wait_cnt != {TO_W{1'b1}})) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky watchdog flag. It only reports the slow access; the FSM keeps
    // waiting. A counter clear also wipes a flag that would set this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_timeout <= 1'b0;
        end else if (cnt_clr) begin
            mem_timeout <= 1'b0;
        end else if ((state == WAIT) && (wait_cnt == TIMEOUT_VAL)) begin
            mem_timeout <= 1'b1;
        end
    end

    // Performance counters. A stall is counted only when it is actually
    // applied, which is exactly when the bubble is injected.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (bubble_ID_EXE),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (flush_IF_ID),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (freeze_all),
        .count (mem_wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed testbench for pipeline_stall_controller. Small counter width and
// a short timeout keep saturation and watchdog cases within a few cycles.
module tb_pipeline_stall_controller;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W        = 8;

    logic             clk;
    logic             rst;
    logic             hazard_Detected;
    logic             Branch_Taken;
    logic             MEM_R_EN;
    logic             MEM_W_EN;
    logic             sram_ready;
    logic             cnt_clr;
    logic             freeze_PC;
    logic             freeze_IF_ID;
    logic             bubble_ID_EXE;
    logic             flush_IF_ID;
    logic             flush_ID_EXE;
    logic             freeze_all;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Control outputs packed as {freeze_PC, freeze_IF_ID, bubble, flush_IF_ID, flush_ID_EXE, freeze_all}
    localparam int CTRL_NONE   = 6'b000000;
    localparam int CTRL_STALL  = 6'b111000;
    localparam int CTRL_FLUSH  = 6'b000110;
    localparam int CTRL_FREEZE = 6'b000001;

    pipeline_stall_controller #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_Detected (hazard_Detected),
        .Branch_Taken    (Branch_Taken),
        .MEM_R_EN        (MEM_R_EN),
        .MEM_W_EN        (MEM_W_EN),
        .sram_ready      (sram_ready),
        .cnt_clr         (cnt_clr),
        .freeze_PC       (freeze_PC),
        .freeze_IF_ID    (freeze_IF_ID),
        .bubble_ID_EXE   (bubble_ID_EXE),
        .flush_IF_ID     (flush_IF_ID),
        .flush_ID_EXE    (flush_ID_EXE),
        .freeze_all      (freeze_all),
        .mem_timeout     (mem_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_wait_cnt    (mem_wait_cnt)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Drives one input vector and lets the combinational outputs settle.
    task automatic applyStimulus(input logic hz, input logic br, input logic rd,
                                 input logic wr, input logic rdy, input logic clr);
        hazard_Detected = hz;
        Branch_Taken    = br;
        MEM_R_EN        = rd;
        MEM_W_EN        = wr;
        sram_ready      = rdy;
        cnt_clr         = clr;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ctrlVec();
        return int'({freeze_PC, freeze_IF_ID, bubble_ID_EXE,
                     flush_IF_ID, flush_ID_EXE, freeze_all});
    endfunction

    task automatic checkCounters(input string tag, input int st, input int fl, input int mw);
        checkOutput({tag, "_stall_cnt"}, int'(stall_cnt), st);
        checkOutput({tag, "_flush_cnt"}, int'(flush_cnt), fl);
        checkOutput({tag, "_mem_wait_cnt"}, int'(mem_wait_cnt), mw);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        step();
        step();
        checkOutput("reset_ctrl", ctrlVec(), CTRL_NONE);
        checkOutput("reset_timeout", int'(mem_timeout), 0);
        checkOutput("reset_state", int'(dut.state), 0);
        checkCounters("reset", 0, 0, 0);
        rst = 1'b0;
        #1;

        $display("[TB] hazard stall for two cycles");
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("hazard_c1", ctrlVec(), CTRL_STALL);
        step();
        checkOutput("hazard_c2", ctrlVec(), CTRL_STALL);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("hazard_done_ctrl", ctrlVec(), CTRL_NONE);
        checkCounters("hazard", 2, 0, 0);

        $display("[TB] hazard and branch in the same cycle");
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("haz_br_ctrl", ctrlVec(), CTRL_FLUSH);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkCounters("haz_br", 2, 1, 0);

        $display("[TB] SRAM load waiting three cycles with branch pending");
        applyStimulus(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("sram_wait_c%0d", i), ctrlVec(), CTRL_FREEZE);
            step();
        end
        checkOutput("sram_wait_state", int'(dut.state), 1);
        applyStimulus(0, 1, 1, 0, 1, 0);
        checkOutput("sram_ready_ctrl", ctrlVec(), CTRL_FLUSH);
        step();
        checkOutput("release_state", int'(dut.state), 2);
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("release_ctrl", ctrlVec(), CTRL_FLUSH);
        step();
        checkOutput("after_release_state", int'(dut.state), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkCounters("sram_wait", 2, 3, 3);

        $display("[TB] zero-wait store then back-to-back loads");
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("zero_wait_ctrl", ctrlVec(), CTRL_NONE);
        step();
        checkOutput("zero_wait_state", int'(dut.state), 0);
        for (int n = 0; n < 2; n++) begin
            applyStimulus(0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("b2b%0d_req", n), ctrlVec(), CTRL_FREEZE);
            step();
            applyStimulus(0, 0, 1, 0, 1, 0);
            checkOutput($sformatf("b2b%0d_ready", n), ctrlVec(), CTRL_NONE);
            step();
            applyStimulus(0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("b2b%0d_release", n), ctrlVec(), CTRL_NONE);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkCounters("b2b", 2, 3, 5);

        $display("[TB] watchdog timeout on a stuck SRAM");
        applyStimulus(0, 0, 1, 0, 0, 0);
        for (int e = 1; e <= 8; e++) begin
            step();
            checkOutput($sformatf("timeout_edge%0d", e), int'(mem_timeout), (e >= 6) ? 1 : 0);
        end
        checkOutput("timeout_still_frozen", int'(freeze_all), 1);
        applyStimulus(0, 0, 1, 0, 1, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        step();
        checkOutput("timeout_sticky", int'(mem_timeout), 1);
        checkCounters("timeout", 2, 3, 13);

        $display("[TB] counter clear beats a same-cycle increment");
        applyStimulus(1, 0, 0, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("clear_timeout", int'(mem_timeout), 0);
        checkCounters("clear", 0, 0, 0);

        $display("[TB] stall counter saturation");
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) begin
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("stall_saturate", int'(stall_cnt), 15);

        $display("[TB] asynchronous reset in the middle of a wait");
        applyStimulus(0, 0, 1, 0, 0, 0);
        step();
        step();
        step();
        checkOutput("pre_reset_state", int'(dut.state), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_ctrl", ctrlVec(), CTRL_NONE);
        checkOutput("async_rst_state", int'(dut.state), 0);
        checkOutput("async_rst_wait_cnt", int'(dut.wait_cnt), 0);
        checkCounters("async_rst", 0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("post_reset_freeze", ctrlVec(), CTRL_FREEZE);
        step();
        applyStimulus(0, 0, 0, 0, 1, 0);
        step();
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("post_reset_mem_wait", int'(mem_wait_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Combines the hazard detector's stall request, the EXE-stage taken-branch signal and the multi-cycle SRAM handshake from the MEM stage. Produces freeze, bubble and flush controls for the PC and the stage registers. Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
CNT_W, 32, width of each performance counter
MEM_TIMEOUT, 64, WAIT cycles (1..2^TO_W-1) after which mem_timeout is set
TO_W, 8, width of the wait-cycle counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
hazard_Detected  in  1  RAW hazard request from hazard detection unit
Branch_Taken  in  1  taken branch resolved in EXE
MEM_R_EN  in  1  MEM-stage load request
MEM_W_EN  in  1  MEM-stage store request
sram_ready  in  1  SRAM controller: access completes this cycle
cnt_clr  in  1  synchronous clear of counters and mem_timeout
freeze_PC  out  1  hold PC
freeze_IF_ID  out  1  hold IF/ID register
bubble_ID_EXE  out  1  load NOP into ID/EXE
flush_IF_ID  out  1  clear IF/ID
flush_ID_EXE  out  1  clear ID/EXE
freeze_all  out  1  hold every stage register (EXE/MEM, MEM/WB included)
mem_timeout  out  1  sticky: an SRAM wait exceeded MEM_TIMEOUT
stall_cnt  out  CNT_W  cycles with hazard stall applied
flush_cnt  out  CNT_W  branch flush events
mem_wait_cnt  out  CNT_W  cycles with freeze_all asserted

Behaviour:
- mem_req = MEM_R_EN | MEM_W_EN.
- FSM states IDLE, WAIT, RELEASE; reset state IDLE.
- IDLE: mem_req & !sram_ready -> WAIT. mem_req & sram_ready = zero-wait access: stay IDLE, no freeze.
- WAIT: !sram_ready -> stay; sram_ready -> RELEASE.
- RELEASE: exactly one cycle, pipeline advances; mem_req ignored this cycle (stale request of retiring instruction); -> IDLE.
- rst mid-WAIT: immediate return to IDLE, wait counter 0.
- freeze_all = (IDLE & mem_req & !sram_ready) | (WAIT & !sram_ready).
- Priority, combinational, same cycle: rst > freeze_all > branch > hazard.
  - freeze_all=1: all other control outputs 0; EXE held, so Branch_Taken is re-evaluated when freeze drops.
  - else Branch_Taken=1: flush_IF_ID=flush_ID_EXE=1; freeze_PC, freeze_IF_ID, bubble_ID_EXE = 0. Branch overrides hazard: the hazarding instruction is squashed.
  - else hazard_Detected=1: freeze_PC=freeze_IF_ID=bubble_ID_EXE=1, flushes 0.
  - else all 0.
- While rst=1 all control outputs 0.
- Wait counter:
  - Cleared on entry to WAIT; increments each WAIT cycle, saturating at 2^TO_W-1.
  - When it equals MEM_TIMEOUT in WAIT, mem_timeout<=1 (sticky).
  - FSM keeps waiting; no abort.
- Counters, registered:
  - stall_cnt +1 on each cycle hazard stall is applied.
  - flush_cnt +1 per cycle with flush asserted.
  - mem_wait_cnt +1 per cycle freeze_all=1.
  - All saturate at 2^CNT_W-1 (no wrap).
- cnt_clr: next edge zeroes the three counters and mem_timeout. It wins over an increment in the same cycle; a timeout set in the same cycle is also cleared.
- Reset values: FSM IDLE, all counters 0, mem_timeout 0.
- Latency: control outputs same cycle as inputs (combinational from state + inputs); counters update at the following edge.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, WAIT=2'd1, RELEASE=2'd2); default CNT_W/MEM_TIMEOUT constants.
- One sub-module, sat_counter (parameter W; inputs inc, clr; rst async), instantiated three times for the performance counters.
- FSM, wait counter and priority logic stay in the top module.

Test Plan:
- Hazard stall: hazard_Detected=1 for 2 cycles, no mem_req -> freeze_PC=freeze_IF_ID=bubble_ID_EXE=1 both cycles, flushes 0; stall_cnt=2.
- Hazard + branch same cycle: hazard_Detected=1, Branch_Taken=1 -> flush_IF_ID=flush_ID_EXE=1, freeze_PC=0, bubble_ID_EXE=0; flush_cnt=1, stall_cnt unchanged.
- SRAM wait: MEM_R_EN=1, sram_ready low 3 cycles then high, Branch_Taken=1 throughout -> freeze_all=1 for 3 cycles with flushes 0; then RELEASE for one cycle with flushes=1; mem_wait_cnt=3.
- Zero-wait and back-to-back: MEM_W_EN=1 & sram_ready=1 -> freeze_all never asserts, FSM stays IDLE. Then two consecutive loads, each waiting 1 cycle -> freeze_all pattern 1,0(RELEASE),1,0.
- Timeout: MEM_TIMEOUT=4, sram_ready held low -> mem_timeout rises once the wait counter reaches 4 and stays 1 after completion. Then cnt_clr=1 -> mem_timeout=0 and all counters 0 next cycle.
- Async reset mid-WAIT: rst pulsed between clock edges -> outputs 0 immediately, FSM IDLE, counters 0. After release, a fresh mem_req & !sram_ready asserts freeze_all the same cycle.
